// File: rtl/fetch_buffer_ctrl.sv
// Fetch buffer controller: sequences enq/deq/clear strobes for the fetch buffer FIFOs,
// keeps the per-packet lane masks and tracks partial consumption of the head packet.
module fetch_buffer_ctrl #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fetch_valid,
  input  logic [FETCH_WIDTH-1:0]       fetch_mask,
  output logic                         fetch_ready,
  output logic                         buf_enq,
  output logic                         buf_deq,
  output logic                         buf_clear,
  output logic                         dec_valid,
  output logic [FETCH_WIDTH-1:0]       dec_mask,
  input  logic [FETCH_WIDTH-1:0]       dec_take,
  input  logic                         redirect,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [0:0]             ST_RUN    = 1'b0;
  localparam logic [0:0]             ST_FLUSH  = 1'b1;
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]       PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1'b1);
  localparam logic [FETCH_WIDTH-1:0] MASK_ZERO = {FETCH_WIDTH{1'b0}};

  logic [0:0]             state_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [FETCH_WIDTH-1:0] consumed_r;
  logic [FETCH_WIDTH-1:0] mask_r [DEPTH];

  logic                   run_s;
  logic [FETCH_WIDTH-1:0] head_s;
  logic [FETCH_WIDTH-1:0] take_s;
  logic                   fire_s;
  logic                   pop_s;

  // Handshake, head view and strobe decode; strobes are held low while reset is asserted
  always_comb begin
    run_s       = (state_r == ST_RUN) && !redirect;
    fetch_ready = run_s && (count_r < CNT_FULL);
    dec_valid   = run_s && (count_r != CNT_ZERO);
    head_s      = mask_r[rd_ptr_r];
    if (dec_valid) begin
      dec_mask = head_s & ~consumed_r;
    end else begin
      dec_mask = MASK_ZERO;
    end
    take_s    = dec_take & dec_mask;
    pop_s     = reset && (take_s != MASK_ZERO) && ((dec_mask & ~take_s) == MASK_ZERO);
    fire_s    = reset && fetch_valid && fetch_ready && (fetch_mask != MASK_ZERO);
    buf_enq   = fire_s;
    buf_deq   = pop_s;
    buf_clear = (state_r == ST_FLUSH);
    count     = count_r;
  end

  // Control state: FSM, pointers, occupancy and head consumption
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      consumed_r <= MASK_ZERO;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (redirect) begin
            state_r    <= ST_FLUSH;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            consumed_r <= MASK_ZERO;
          end else begin
            if (fire_s) begin
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
              rd_ptr_r   <= rd_ptr_r + PTR_ONE;
              consumed_r <= MASK_ZERO;
            end else begin
              consumed_r <= consumed_r | take_s;
            end
            if (fire_s && !pop_s) begin
              count_r <= count_r + CNT_ONE;
            end else if (!fire_s && pop_s) begin
              count_r <= count_r - CNT_ONE;
            end
          end
        end
        ST_FLUSH: begin
          if (redirect) begin
            state_r <= ST_FLUSH;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          wr_ptr_r   <= PTR_ZERO;
          rd_ptr_r   <= PTR_ZERO;
          count_r    <= CNT_ZERO;
          consumed_r <= MASK_ZERO;
        end
      endcase
    end
  end

  // Lane-mask storage, one entry per buffered packet
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_r[i] <= MASK_ZERO;
      end
    end else if (fire_s) begin
      mask_r[wr_ptr_r] <= fetch_mask;
    end
  end

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
// Self-checking bench for fetch_buffer_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffered packets.
module tb_fetch_buffer_ctrl;

  localparam int FW    = 4;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [FW-1:0] fetch_mask = 4'h0;
  logic          fetch_ready;
  logic          buf_enq, buf_deq, buf_clear, dec_valid;
  logic [FW-1:0] dec_mask;
  logic [FW-1:0] dec_take = 4'h0;
  logic          redirect = 1'b0;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining lanes of each buffered packet, head first
  logic [FW-1:0] model_q[$];
  bit            model_flush = 1'b0;
  bit            exp_ready, exp_dv, exp_enq, exp_deq, exp_clear;
  logic [FW-1:0] exp_dmask, exp_take;
  int            exp_count;

  always #5 clock = ~clock;

  fetch_buffer_ctrl #(.FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_mask(fetch_mask),
    .fetch_ready(fetch_ready), .buf_enq(buf_enq), .buf_deq(buf_deq), .buf_clear(buf_clear),
    .dec_valid(dec_valid), .dec_mask(dec_mask), .dec_take(dec_take), .redirect(redirect),
    .count(count)
  );

  function automatic void model_eval();
    bit run;
    run       = !model_flush && !redirect;
    exp_ready = run && (model_q.size() < DEPTH);
    exp_dv    = run && (model_q.size() != 0);
    exp_dmask = 4'h0;
    if (exp_dv) exp_dmask = model_q[0];
    exp_take  = dec_take & exp_dmask;
    exp_deq   = (exp_take != 4'h0) && (exp_take == exp_dmask);
    exp_enq   = fetch_valid && exp_ready && (fetch_mask != 4'h0);
    exp_clear = model_flush;
    exp_count = model_q.size();
  endfunction

  function automatic void model_commit();
    if (redirect) begin
      model_q.delete();
      model_flush = 1'b1;
    end else if (model_flush) begin
      model_flush = 1'b0;
    end else begin
      if (exp_deq) void'(model_q.pop_front());
      else if (exp_take != 4'h0) model_q[0] = model_q[0] & ~exp_take;
      if (exp_enq) model_q.push_back(fetch_mask);
    end
  endfunction

  task automatic apply(input bit fv, input logic [FW-1:0] fm, input logic [FW-1:0] tk, input bit rd);
    @(negedge clock);
    fetch_valid = fv; fetch_mask = fm; dec_take = tk; redirect = rd;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", fetch_ready); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid got %b exp 0", dec_valid); end
    n_checks++; if (buf_clear !== 1'b0) begin n_fail++; $display("FAIL rst_clear got %b exp 0", buf_clear); end
    @(negedge clock); reset = 1'b1;
    apply(1'b0, 4'h0, 4'h0, 1'b0);
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b exp 1", fetch_ready); end
    n_checks++; if (dec_mask !== 4'h0) begin n_fail++; $display("FAIL post_rst_dec_mask got %h exp 0", dec_mask); end
    advance();
  endtask

  task automatic test_enqueue();
    apply(1'b1, 4'hF, 4'h0, 1'b0);
    n_checks++; if (buf_enq !== 1'b1) begin n_fail++; $display("FAIL enq1 got %b exp 1", buf_enq); end
    advance();
    apply(1'b1, 4'h3, 4'h0, 1'b0);
    n_checks++; if (buf_enq !== 1'b1) begin n_fail++; $display("FAIL enq2 got %b exp 1", buf_enq); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL enq_count1 got %0d exp 1", count); end
    n_checks++; if (dec_mask !== 4'hF) begin n_fail++; $display("FAIL enq_head got %h exp f", dec_mask); end
    advance();
    apply(1'b0, 4'h0, 4'h0, 1'b0);
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL enq_count2 got %0d exp 2", count); end
    n_checks++; if (buf_enq !== 1'b0) begin n_fail++; $display("FAIL enq_idle got %b exp 0", buf_enq); end
    advance();
  endtask

  task automatic test_partial();
    apply(1'b0, 4'h0, 4'h3, 1'b0);
    n_checks++; if (buf_deq !== 1'b0) begin n_fail++; $display("FAIL part_nodeq got %b exp 0", buf_deq); end
    advance();
    apply(1'b0, 4'h0, 4'hC, 1'b0);
    n_checks++; if (dec_mask !== 4'hC) begin n_fail++; $display("FAIL part_rem got %h exp c", dec_mask); end
    n_checks++; if (buf_deq !== 1'b1) begin n_fail++; $display("FAIL part_deq got %b exp 1", buf_deq); end
    advance();
    apply(1'b0, 4'h0, 4'hF, 1'b0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL part_count got %0d exp 1", count); end
    n_checks++; if (dec_mask !== 4'h3) begin n_fail++; $display("FAIL part_next got %h exp 3", dec_mask); end
    advance();
  endtask

  task automatic test_full();
    logic [FW-1:0] m [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 4'($urandom_range(1, 15));
      apply(1'b1, m[i], 4'h0, 1'b0);
      n_checks++; if (buf_enq !== 1'b1) begin n_fail++; $display("FAIL fill_enq %0d got %b exp 1", i, buf_enq); end
      advance();
    end
    apply(1'b1, 4'hF, 4'h0, 1'b0);
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", fetch_ready); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d exp 8", count); end
    n_checks++; if (buf_enq !== 1'b0) begin n_fail++; $display("FAIL full_noenq got %b exp 0", buf_enq); end
    advance();
    apply(1'b1, 4'hF, m[0], 1'b0);
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %b exp 0", fetch_ready); end
    n_checks++; if (buf_deq !== 1'b1) begin n_fail++; $display("FAIL full_pop_deq got %b exp 1", buf_deq); end
    advance();
    apply(1'b1, 4'h5, 4'h0, 1'b0);
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL after_pop_ready got %b exp 1", fetch_ready); end
    n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL after_pop_count got %0d exp 7", count); end
    n_checks++; if (dec_mask !== m[1]) begin n_fail++; $display("FAIL after_pop_head got %h exp %h", dec_mask, m[1]); end
    advance();
    for (int j = 1; j <= DEPTH; j++) begin
      apply(1'b0, 4'h0, 4'hF, 1'b0);
      if (j < DEPTH) begin
        n_checks++; if (dec_mask !== m[j]) begin n_fail++; $display("FAIL drain_head %0d got %h exp %h", j, dec_mask, m[j]); end
      end else begin
        n_checks++; if (dec_mask !== 4'h5) begin n_fail++; $display("FAIL wrap_head got %h exp 5", dec_mask); end
      end
      n_checks++; if (buf_deq !== 1'b1) begin n_fail++; $display("FAIL drain_deq %0d got %b exp 1", j, buf_deq); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 4'h9, 4'h0, 1'b0);
    advance();
    apply(1'b1, 4'h6, 4'hF, 1'b0);
    n_checks++; if (buf_enq !== 1'b1 || buf_deq !== 1'b1) begin
      n_fail++; $display("FAIL b2b_strobes got enq=%b deq=%b exp 1 1", buf_enq, buf_deq); end
    advance();
    apply(1'b0, 4'h0, 4'hF, 1'b0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL b2b_count got %0d exp 1", count); end
    n_checks++; if (dec_mask !== 4'h6) begin n_fail++; $display("FAIL b2b_head got %h exp 6", dec_mask); end
    advance();
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 5; i++) begin apply(1'b1, 4'hF, 4'h0, 1'b0); advance(); end
    apply(1'b0, 4'h0, 4'h3, 1'b0); advance();
    apply(1'b1, 4'hA, 4'hF, 1'b1);
    n_checks++; if (dec_valid !== 1'b0 || dec_mask !== 4'h0) begin
      n_fail++; $display("FAIL redir_dec got valid=%b mask=%h exp 0 0", dec_valid, dec_mask); end
    n_checks++; if (fetch_ready !== 1'b0 || buf_enq !== 1'b0 || buf_deq !== 1'b0) begin
      n_fail++; $display("FAIL redir_strobes got rdy=%b enq=%b deq=%b exp 0 0 0", fetch_ready, buf_enq, buf_deq); end
    advance();
    apply(1'b1, 4'h7, 4'h0, 1'b0);
    n_checks++; if (buf_clear !== 1'b1) begin n_fail++; $display("FAIL flush_clear got %b exp 1", buf_clear); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    n_checks++; if (fetch_ready !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_hs got rdy=%b dv=%b exp 0 0", fetch_ready, dec_valid); end
    advance();
    apply(1'b1, 4'h7, 4'h0, 1'b0);
    n_checks++; if (fetch_ready !== 1'b1 || buf_clear !== 1'b0) begin
      n_fail++; $display("FAIL post_flush got rdy=%b clr=%b exp 1 0", fetch_ready, buf_clear); end
    advance();
    apply(1'b0, 4'h0, 4'h0, 1'b1); advance();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'h0, 4'h0, k < 2);
      n_checks++; if (buf_clear !== 1'b1) begin n_fail++; $display("FAIL held_clear %0d got %b exp 1", k, buf_clear); end
      advance();
    end
    apply(1'b0, 4'h0, 4'h0, 1'b0);
    n_checks++; if (buf_clear !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL held_end got clr=%b rdy=%b exp 0 1", buf_clear, fetch_ready); end
    advance();
  endtask

  task automatic test_zero_mask();
    apply(1'b1, 4'h0, 4'h0, 1'b0);
    n_checks++; if (buf_enq !== 1'b0) begin n_fail++; $display("FAIL zmask_enq got %b exp 0", buf_enq); end
    advance();
    apply(1'b0, 4'h0, 4'h0, 1'b0);
    n_checks++; if (count !== 4'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL zmask_count got %0d dv=%b exp 0 0", count, dec_valid); end
    advance();
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      apply($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), $urandom_range(0, 24) == 0);
      n_checks++; if (fetch_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d got %b exp %b", c, fetch_ready, exp_ready); end
      n_checks++; if (dec_valid !== exp_dv) begin n_fail++; $display("FAIL rnd_dv c%0d got %b exp %b", c, dec_valid, exp_dv); end
      n_checks++; if (dec_mask !== exp_dmask) begin n_fail++; $display("FAIL rnd_mask c%0d got %h exp %h", c, dec_mask, exp_dmask); end
      n_checks++; if (buf_enq !== exp_enq) begin n_fail++; $display("FAIL rnd_enq c%0d got %b exp %b", c, buf_enq, exp_enq); end
      n_checks++; if (buf_deq !== exp_deq) begin n_fail++; $display("FAIL rnd_deq c%0d got %b exp %b", c, buf_deq, exp_deq); end
      n_checks++; if (buf_clear !== exp_clear) begin n_fail++; $display("FAIL rnd_clear c%0d got %b exp %b", c, buf_clear, exp_clear); end
      n_checks++; if (count !== 4'(exp_count)) begin n_fail++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, exp_count); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin apply(1'b1, 4'hF, 4'h0, 1'b0); advance(); end
    @(negedge clock);
    fetch_valid = 1'b1; fetch_mask = 4'hF; dec_take = 4'hF; redirect = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || dec_valid !== 1'b0 || dec_mask !== 4'h0) begin
      n_fail++; $display("FAIL arst_state got cnt=%0d dv=%b mask=%h exp 0 0 0", count, dec_valid, dec_mask); end
    n_checks++; if (buf_enq !== 1'b0 || buf_deq !== 1'b0 || buf_clear !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_strobes got enq=%b deq=%b clr=%b rdy=%b exp 0 0 0 1", buf_enq, buf_deq, buf_clear, fetch_ready); end
    @(negedge clock); reset = 1'b1;
    model_q.delete(); model_flush = 1'b0;
    apply(1'b1, 4'hC, 4'h0, 1'b0); advance();
    apply(1'b0, 4'h0, 4'h0, 1'b1); advance();
    @(negedge clock);
    fetch_valid = 1'b0; redirect = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (buf_clear !== 1'b0) begin n_fail++; $display("FAIL arst_flush_clear got %b exp 0", buf_clear); end
    @(negedge clock); reset = 1'b1; redirect = 1'b0;
    model_q.delete(); model_flush = 1'b0;
    apply(1'b1, 4'h2, 4'h0, 1'b0);
    n_checks++; if (fetch_ready !== 1'b1 || buf_enq !== 1'b1) begin
      n_fail++; $display("FAIL arst_resume got rdy=%b enq=%b exp 1 1", fetch_ready, buf_enq); end
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_enqueue();
    test_partial();
    test_full();
    test_back_to_back();
    test_redirect();
    test_zero_mask();
    test_random(400);
    test_async_reset();
    test_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
